// File: rtl/csr_timer_bank_if.sv
// csr_timer_bank_if
//   Register access bundle between the CSR decode and the timer bank.
//   master : CSR decode side, drives write/read requests, receives rd_value.
//   slave  : timer bank side, consumes requests, returns combinational rd_value.
//   Signals: wr_en, wr_ch, wr_sel, wr_wvalue, wr_wmask (masked write port)
//            rd_ch, rd_sel, rd_value                  (combinational read port)
interface csr_timer_bank_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 32
);
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [1:0]       wr_sel;
    logic [CNT_W-1:0] wr_wvalue;
    logic [CNT_W-1:0] wr_wmask;
    logic [CH_W-1:0]  rd_ch;
    logic [1:0]       rd_sel;
    logic [CNT_W-1:0] rd_value;

    modport master (
        output wr_en, wr_ch, wr_sel, wr_wvalue, wr_wmask, rd_ch, rd_sel,
        input  rd_value
    );

    modport slave (
        input  wr_en, wr_ch, wr_sel, wr_wvalue, wr_wmask, rd_ch, rd_sel,
        output rd_value
    );
endinterface

// File: rtl/csr_timer_bank.sv
// csr_timer_bank
//   Multi-channel countdown timer bank beside the CSR file. Each channel has
//   TCFG {initval, periodic, en}, a read-only TVAL counter and a TICLR
//   pending-clear register, all written with masked-merge semantics.
//   A shared free-running prescaler generates the count tick.
//   Ports:
//     clk, resetn   clock, asynchronous active-low reset
//     bus (slave)   masked register write port and combinational read port
//     irq_mask      per-channel interrupt enable
//     irq_pending   per-channel registered pending flags
//     irq           OR of (irq_pending & irq_mask), feeds ESTAT.IS[11]
module csr_timer_bank #(
    parameter int NCH      = 4,
    parameter int CH_W     = 2,
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                resetn,
    csr_timer_bank_if.slave     bus,
    input  logic [NCH-1:0]      irq_mask,
    output logic [NCH-1:0]      irq_pending,
    output logic                irq
);

    localparam int               IV_W      = CNT_W - 2;
    localparam logic [1:0]       SEL_TCFG  = 2'd0;
    localparam logic [1:0]       SEL_TVAL  = 2'd1;
    localparam logic [1:0]       SEL_TICLR = 2'd2;
    localparam logic [CNT_W-1:0] CNT_STOP  = '1;

    logic tick;

    if (PRESCALE == 1) begin : g_no_ps
        assign tick = 1'b1;
    end else begin : g_ps
        localparam int            PS_W    = $clog2(PRESCALE);
        localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

        logic [PS_W-1:0] ps_cnt;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                ps_cnt <= '0;
            end else if (ps_cnt == PS_LAST) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + 1'b1;
            end
        end

        assign tick = (ps_cnt == PS_LAST);
    end

    logic [CNT_W-1:0] cfg_rd [NCH];
    logic [CNT_W-1:0] cnt_rd [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);

        logic             en_q,  en_d;
        logic             per_q, per_d;
        logic [IV_W-1:0]  iv_q,  iv_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pend_q, pend_d;
        logic [CNT_W-1:0] cfg_cur, cfg_new;
        logic             cfg_wr, clr_wr, fire;

        assign cfg_cur = {iv_q, per_q, en_q};
        assign cfg_new = (bus.wr_wmask & bus.wr_wvalue) | (~bus.wr_wmask & cfg_cur);
        assign cfg_wr  = bus.wr_en && (bus.wr_ch == IDX) && (bus.wr_sel == SEL_TCFG);
        assign clr_wr  = bus.wr_en && (bus.wr_ch == IDX) && (bus.wr_sel == SEL_TICLR)
                         && bus.wr_wmask[0] && bus.wr_wvalue[0];

        // A TCFG write owns the channel for that edge: it either reloads or
        // freezes the counter, so the tick is not applied on top of it.
        assign fire = tick && en_q && (cnt_q != CNT_STOP) && !cfg_wr;

        always_comb begin
            en_d  = en_q;
            per_d = per_q;
            iv_d  = iv_q;
            cnt_d = cnt_q;
            if (cfg_wr) begin
                en_d  = cfg_new[0];
                per_d = cfg_new[1];
                iv_d  = cfg_new[CNT_W-1:2];
                if (cfg_new[0]) begin
                    cnt_d = {cfg_new[CNT_W-1:2], 2'b00};
                end
            end else if (fire) begin
                if (cnt_q == '0) begin
                    cnt_d = per_q ? {iv_q, 2'b00} : CNT_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        // Expiry beats a same-cycle clear so an interrupt is never lost.
        assign pend_d = (fire && (cnt_q == '0)) || (pend_q && !clr_wr);

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                en_q   <= 1'b0;
                per_q  <= 1'b0;
                iv_q   <= '0;
                cnt_q  <= CNT_STOP;
                pend_q <= 1'b0;
            end else begin
                en_q   <= en_d;
                per_q  <= per_d;
                iv_q   <= iv_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
            end
        end

        assign irq_pending[i] = pend_q;
        assign cfg_rd[i]      = cfg_cur;
        assign cnt_rd[i]      = cnt_q;
    end

    // Channel indices with no matching channel fall through to zero.
    always_comb begin
        bus.rd_value = '0;
        for (int c = 0; c < NCH; c++) begin
            if (bus.rd_ch == CH_W'(c)) begin
                case (bus.rd_sel)
                    SEL_TCFG: bus.rd_value = cfg_rd[c];
                    SEL_TVAL: bus.rd_value = cnt_rd[c];
                    default:  bus.rd_value = '0;
                endcase
            end
        end
    end

    assign irq = |(irq_pending & irq_mask);

endmodule
